uart_tx_sched: RTL

- Multi-requester transmit scheduler in front of the existing edge-triggered UART transmitter.
- The transmitter has no busy or ready output. It starts a frame on each rising edge of its enable and latches data two cycles after that edge.
- This block arbitrates round-robin among NUM_REQ byte sources using a valid/ready handshake. It presents one byte at a time, pulses the enable, and self-times each frame, so frames are never overlapped or truncated.

---
 rtl/uart_tx_sched.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one byte per frame to an edge-triggered UART transmitter.
// Latency: req_ready is combinational, so data and enable go out on the edge after the accept. Frames are spaced by FRAME_CYC+1 cycles.
// Backpressure: req_ready stays low in EN and WAIT, and a requester holds valid/data until it sees ready.
module uart_tx_sched #(
    parameter int NUM_REQ     = 4,
    parameter int SYS_CLK_FRE = 50_000_000,
    parameter int BPS         = 115200,
    parameter int EN_HIGH_CYC = 4,
    parameter int GAP_BITS    = 1,
    localparam int BPS_CNT    = SYS_CLK_FRE / BPS,
    localparam int FRAME_CYC  = (10 + GAP_BITS) * BPS_CNT,
    localparam int GW         = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_data,
    output logic                 uart_tx_en,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    typedef enum logic [1:0] {ST_IDLE, ST_EN, ST_WAIT} state_t;

    state_t        state_q, state_d;
    logic [23:0]   cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          en_q, en_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;

    logic          any_vld;
    logic [GW-1:0] win;

    // Search starts one past the last grant, so a held request waits at most NUM_REQ-1 frames.
    always_comb begin
        any_vld = |req_valid;
        win     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                win = GW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && any_vld && !sys_rst) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        en_d     = en_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_vld) begin
                    data_d   = req_data[8*int'(win) +: 8];
                    en_d     = 1'b1;
                    grant_d  = win;
                    rr_ptr_d = win;
                    cnt_d    = 24'd1;
                    state_d  = ST_EN;
                end
            end
            ST_EN: begin
                cnt_d = cnt_q + 24'd1;
                if (cnt_q == 24'(EN_HIGH_CYC)) begin
                    en_d    = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 24'd1;
                if (cnt_q == 24'(FRAME_CYC)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            en_q     <= 1'b0;
            grant_q  <= '0;
            rr_ptr_q <= GW'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            en_q     <= en_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign uart_data  = data_q;
    assign uart_tx_en = en_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
